// File: rtl/nes_joypad_port.sv
// ============================================================================
// nes_joypad_port: NES $4016/$4017 controller port with a USB HID keycode
// decoder and a 4021-style shift register model. Rev 1.0
// ============================================================================
`default_nettype none

module nes_joypad_port #(
   parameter logic [7:0] KEY_A      = 8'h1D,
   parameter logic [7:0] KEY_B      = 8'h1B,
   parameter logic [7:0] KEY_SELECT = 8'h2C,
   parameter logic [7:0] KEY_START  = 8'h28,
   parameter logic [7:0] KEY_UP     = 8'h52,
   parameter logic [7:0] KEY_DOWN   = 8'h51,
   parameter logic [7:0] KEY_LEFT   = 8'h50,
   parameter logic [7:0] KEY_RIGHT  = 8'h4F,
   parameter logic [2:0] OPEN_BUS   = 3'b010
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [7:0]  keycode,
   input  logic        cpu_en,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rw_n,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  rdata,
   output logic        rdata_valid,
   output logic        strobe_dbg,
   output logic [7:0]  buttons_dbg
);

   localparam logic [15:0] ADDR_JOY1 = 16'h4016;
   localparam logic [15:0] ADDR_JOY2 = 16'h4017;

   logic [7:0] buttons_q;
   logic [7:0] shift_q;
   logic       strobe_q;
   logic [3:0] reads_q;

   logic [7:0] buttons_d;
   logic       key_present;
   logic       sel_joy1;
   logic       sel_joy2;
   logic       wr_joy1;
   logic       rd_joy1;
   logic       read_bit;

   // Keycode 8'h00 means "no key" and must never light a button.
   assign key_present = (keycode != 8'h00);
   assign buttons_d   = {8{key_present}} & {
      keycode == KEY_RIGHT,
      keycode == KEY_LEFT,
      keycode == KEY_DOWN,
      keycode == KEY_UP,
      keycode == KEY_START,
      keycode == KEY_SELECT,
      keycode == KEY_B,
      keycode == KEY_A
   };

   assign sel_joy1 = (cpu_addr == ADDR_JOY1);
   assign sel_joy2 = (cpu_addr == ADDR_JOY2);
   assign wr_joy1  = cpu_en & ~cpu_rw_n & sel_joy1;
   assign rd_joy1  = cpu_en &  cpu_rw_n & sel_joy1;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         buttons_q <= 8'h00;
         shift_q   <= 8'h00;
         strobe_q  <= 1'b0;
         reads_q   <= 4'd0;
      end else begin
         buttons_q <= buttons_d;
         if (wr_joy1)
            strobe_q <= cpu_wdata[0];
         // A held strobe keeps reloading; the edge of a 1->0 write also loads.
         if (strobe_q) begin
            shift_q <= buttons_q;
            if (wr_joy1 && !cpu_wdata[0])
               reads_q <= 4'd0;
         end else if (rd_joy1) begin
            shift_q <= {1'b1, shift_q[7:1]};
            if (reads_q != 4'd8)
               reads_q <= reads_q + 4'd1;
         end
      end
   end

   // Controller 2 is unpopulated, so its data bit is always released (0).
   assign read_bit    = sel_joy1 & (strobe_q ? buttons_q[0] : shift_q[0]);
   assign rdata_valid = Reset_n & cpu_en & cpu_rw_n & (sel_joy1 | sel_joy2);
   assign rdata       = rdata_valid ? {OPEN_BUS, 4'b0000, read_bit} : 8'h00;

   assign strobe_dbg  = strobe_q;
   assign buttons_dbg = buttons_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_joypad_port.sv
// ============================================================================
// tb_nes_joypad_port: scoreboard-based bench for the NES joypad port. Rev 1.0
// ============================================================================
`default_nettype none

module tb_nes_joypad_port;

   logic        Clk;
   logic        Reset_n;
   logic [7:0]  keycode;
   logic        cpu_en;
   logic [15:0] cpu_addr;
   logic        cpu_rw_n;
   logic [7:0]  cpu_wdata;
   logic [7:0]  rdata;
   logic        rdata_valid;
   logic        strobe_dbg;
   logic [7:0]  buttons_dbg;

   int checks = 0;
   int errors = 0;

   // Scoreboard entries are {rdata_valid, rdata}.
   logic [8:0] sb[$];

   nes_joypad_port dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .keycode     (keycode),
      .cpu_en      (cpu_en),
      .cpu_addr    (cpu_addr),
      .cpu_rw_n    (cpu_rw_n),
      .cpu_wdata   (cpu_wdata),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .strobe_dbg  (strobe_dbg),
      .buttons_dbg (buttons_dbg)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // Independent reference of the keyboard-to-button mapping.
   function automatic logic [7:0] ref_buttons(input logic [7:0] k);
      case (k)
         8'h1D:   return 8'h01;
         8'h1B:   return 8'h02;
         8'h2C:   return 8'h04;
         8'h28:   return 8'h08;
         8'h52:   return 8'h10;
         8'h51:   return 8'h20;
         8'h50:   return 8'h40;
         8'h4F:   return 8'h80;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [8:0] ref_read(input logic valid, input logic b);
      return valid ? {1'b1, 3'b010, 4'b0000, b} : 9'h000;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_en = 1'b1; cpu_rw_n = 1'b0; cpu_addr = a; cpu_wdata = d;
      @(posedge Clk);
      #1;
      cpu_en = 1'b0; cpu_rw_n = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
   endtask

   // Issues one read cycle and returns what the bus showed mid-cycle.
   task automatic cpu_read(input logic [15:0] a, output logic [8:0] obs);
      cpu_en = 1'b1; cpu_rw_n = 1'b1; cpu_addr = a;
      @(negedge Clk);
      obs = {rdata_valid, rdata};
      @(posedge Clk);
      #1;
      cpu_en = 1'b0; cpu_addr = 16'h0000;
   endtask

   task automatic latch(input logic [7:0] k);
      keycode = k;
      idle(2);
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
   endtask

   task automatic test_reset;
      logic [8:0] obs;
      Reset_n = 1'b0; keycode = 8'h1D;
      cpu_en = 1'b0; cpu_rw_n = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      idle(3);
      sb.push_back(ref_read(1'b0, 1'b0));
      cpu_read(16'h4016, obs);
      checks++;
      if (obs !== sb.pop_front()) begin
         errors++; $display("FAIL reset_read: actual=%h required=000", obs);
      end
      checks++;
      if (strobe_dbg !== 1'b0 || buttons_dbg !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: actual strobe=%b buttons=%h required strobe=0 buttons=00",
                  strobe_dbg, buttons_dbg);
      end
      Reset_n = 1'b1;
      idle(2);
   endtask

   task automatic test_sequence(input string name, input logic [7:0] k);
      logic [8:0] obs;
      logic [8:0] exp;
      logic [7:0] btn;
      btn = ref_buttons(k);
      keycode = k;
      idle(2);
      checks++;
      if (buttons_dbg !== btn) begin
         errors++;
         $display("FAIL %s_buttons: actual=%h required=%h", name, buttons_dbg, btn);
      end
      cpu_write(16'h4016, 8'h01);
      checks++;
      if (strobe_dbg !== 1'b1) begin
         errors++; $display("FAIL %s_strobe: actual=%b required=1", name, strobe_dbg);
      end
      cpu_write(16'h4016, 8'h00);
      for (int i = 0; i < 10; i++) begin
         sb.push_back(ref_read(1'b1, (i < 8) ? btn[i] : 1'b1));
         cpu_read(16'h4016, obs);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s_read%0d: actual=%h required=%h", name, i + 1, obs, exp);
         end
      end
   endtask

   task automatic test_strobe_held;
      logic [8:0] obs;
      logic [8:0] exp;
      logic [7:0] ks [4] = '{8'h00, 8'h1D, 8'h00, 8'h1D};
      cpu_write(16'h4016, 8'h01);
      for (int i = 0; i < 4; i++) begin
         keycode = ks[i];
         idle(2);
         // Two reads back to back: no shifting may occur while strobe is high.
         for (int j = 0; j < 2; j++) begin
            sb.push_back(ref_read(1'b1, ref_buttons(ks[i]) == 8'h01));
            cpu_read(16'h4016, obs);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL strobe_held_%0d_%0d: actual=%h required=%h", i, j, obs, exp);
            end
         end
      end
      cpu_write(16'h4016, 8'h00);
   endtask

   task automatic test_latch_hold;
      logic [8:0] obs;
      logic [8:0] exp;
      latch(8'h28);
      keycode = 8'h00;
      idle(3);
      for (int i = 0; i < 8; i++) begin
         sb.push_back(ref_read(1'b1, i == 3));
         cpu_read(16'h4016, obs);
         exp = sb.pop_front();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL latch_hold_read%0d: actual=%h required=%h", i + 1, obs, exp);
         end
      end
   endtask

   task automatic test_port2;
      logic [8:0] obs;
      logic [8:0] exp;
      latch(8'h1B);
      // Controller-2 reads and writes, plus an unrelated address, sit between
      // the two $4016 reads and must not disturb the shift state.
      sb.push_back(ref_read(1'b1, 1'b0));
      sb.push_back(ref_read(1'b1, 1'b0));
      sb.push_back(ref_read(1'b0, 1'b0));
      sb.push_back(ref_read(1'b1, 1'b1));
      cpu_read(16'h4016, obs);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL port2_first: actual=%h required=%h", obs, exp);
      end
      cpu_write(16'h4017, 8'h01);
      checks++;
      if (strobe_dbg !== 1'b0) begin
         errors++; $display("FAIL port2_write_ignored: actual=%b required=0", strobe_dbg);
      end
      cpu_read(16'h4017, obs);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL port2_read: actual=%h required=%h", obs, exp);
      end
      cpu_read(16'h4018, obs);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL other_addr: actual=%h required=%h", obs, exp);
      end
      cpu_read(16'h4016, obs);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL port2_second: actual=%h required=%h", obs, exp);
      end
   endtask

   task automatic test_reset_mid;
      logic [8:0] obs;
      logic [8:0] exp;
      latch(8'h1D);
      for (int i = 0; i < 3; i++) begin
         sb.push_back(ref_read(1'b1, i == 0));
         cpu_read(16'h4016, obs);
         exp = sb.pop_front(); checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL reset_mid_pre%0d: actual=%h required=%h", i, obs, exp);
         end
      end
      Reset_n = 1'b0;
      idle(1);
      sb.push_back(ref_read(1'b0, 1'b0));
      cpu_read(16'h4016, obs);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL reset_mid_during: actual=%h required=%h", obs, exp);
      end
      checks++;
      if (buttons_dbg !== 8'h00) begin
         errors++; $display("FAIL reset_mid_buttons: actual=%h required=00", buttons_dbg);
      end
      Reset_n = 1'b1;
      idle(2);
      checks++;
      if (strobe_dbg !== 1'b0) begin
         errors++; $display("FAIL reset_mid_strobe: actual=%b required=0", strobe_dbg);
      end
      sb.push_back(ref_read(1'b1, 1'b0));
      cpu_read(16'h4016, obs);
      exp = sb.pop_front(); checks++;
      if (obs !== exp) begin
         errors++; $display("FAIL reset_mid_after: actual=%h required=%h", obs, exp);
      end
   endtask

   initial begin
      test_reset();
      test_sequence("btn_a", 8'h1D);
      test_sequence("btn_right", 8'h4F);
      test_sequence("btn_select", 8'h2C);
      test_sequence("no_key", 8'h00);
      test_strobe_held();
      test_latch_hold();
      test_port2();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: actual=%0d required=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
